// File: rtl/ram16x4_ctrl_if.sv
// Host-side request/response bundle between the SAP control sequencer and ram16x4_ctrl.
// master: the sequencer issuing requests; slave: the RAM controller serving them.
interface ram16x4_ctrl_if;
  logic       req;
  logic       we;
  logic [3:0] addr;
  logic [3:0] wdata;
  logic       ready;
  logic       done;
  logic [3:0] rdata;
  logic       verify_err;

  modport master (
    output req, we, addr, wdata,
    input  ready, done, rdata, verify_err
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, done, rdata, verify_err
  );
endinterface

// File: rtl/ram16x4_ctrl.sv
// ram16x4_ctrl: single-word initiator for the SN74189 16x4 scratchpad RAM.
// Generates registered, glitch-free S_bar/W_bar strobes with address/data setup
// and hold, and returns true (uncomplemented) read data.
// Optional feature macro: RAM_CTRL_READBACK_EN (read back and verify every write).
module ram16x4_ctrl #(
  parameter int unsigned WR_PULSE = 2,
  parameter int unsigned RD_WAIT  = 2
) (
  input  logic                 CLK,
  input  logic                 CLR,
  ram16x4_ctrl_if.slave        host,
  output logic [3:0]           A,
  output logic [3:0]           DI,
  input  logic [3:0]           DO,
  output logic                 S_bar,
  output logic                 W_bar
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_WSTROBE = 3'd2,
    S_WHOLD   = 3'd3,
    S_RACCESS = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             op_we;
  logic [3:0]       rdata_q;
  logic             ready_q;
  logic             done_q;

  logic             accept_c;
  logic             cnt_zero_c;
  logic             capture_c;
  logic             s_bar_nxt;
  logic             w_bar_nxt;
  logic             ready_nxt;
  logic             done_nxt;

  assign accept_c   = (state == S_IDLE) && host.req;
  assign cnt_zero_c = (cnt == '0);
  // Last RACCESS cycle: ~DO is sampled at the edge that ends it.
  assign capture_c  = (state == S_RACCESS) && cnt_zero_c;

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (host.req) state_nxt = S_SETUP;
      S_SETUP:   state_nxt = op_we ? S_WSTROBE : S_RACCESS;
      S_WSTROBE: if (cnt_zero_c) state_nxt = S_WHOLD;
`ifdef RAM_CTRL_READBACK_EN
      S_WHOLD:   state_nxt = S_RACCESS;
`else
      S_WHOLD:   state_nxt = S_DONE;
`endif
      S_RACCESS: if (cnt_zero_c) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the next state so every strobe leaves a flop.
  always_comb begin
    s_bar_nxt = 1'b1;
    w_bar_nxt = 1'b1;
    ready_nxt = 1'b0;
    done_nxt  = 1'b0;
    case (state_nxt)
      S_IDLE:    ready_nxt = 1'b1;
      S_WSTROBE: begin
        s_bar_nxt = 1'b0;
        w_bar_nxt = 1'b0;
      end
      S_RACCESS: s_bar_nxt = 1'b0;
      S_DONE:    done_nxt  = 1'b1;
      default:   ;
    endcase
  end

  // State and strobe registers; CLR drops any strobe at the same edge.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state   <= S_IDLE;
      S_bar   <= 1'b1;
      W_bar   <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      S_bar   <= s_bar_nxt;
      W_bar   <= w_bar_nxt;
      ready_q <= ready_nxt;
      done_q  <= done_nxt;
    end
  end

  // Request latch, strobe-width counter and read capture.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      A       <= '0;
      DI      <= '0;
      op_we   <= 1'b0;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      if (accept_c) begin
        A     <= host.addr;
        DI    <= host.wdata;
        op_we <= host.we;
      end

      if ((state_nxt == S_WSTROBE) && (state != S_WSTROBE)) begin
        cnt <= WR_LOAD;
      end else if ((state_nxt == S_RACCESS) && (state != S_RACCESS)) begin
        cnt <= RD_LOAD;
      end else if (!cnt_zero_c) begin
        cnt <= cnt - CNT_W'(1);
      end

      // Read-back captures never disturb host read data.
      if (capture_c && !op_we) begin
        rdata_q <= ~DO;
      end
    end
  end

`ifdef RAM_CTRL_READBACK_EN
  logic verify_err_q;

  // Compare read-back against the still-held write data; cleared by the next request.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      verify_err_q <= 1'b0;
    end else if (accept_c) begin
      verify_err_q <= 1'b0;
    end else if (capture_c && op_we) begin
      verify_err_q <= ((~DO) != DI);
    end
  end

  assign host.verify_err = verify_err_q;
`else
  assign host.verify_err = 1'b0;
`endif

  assign host.ready = ready_q;
  assign host.done  = done_q;
  assign host.rdata = rdata_q;

endmodule

// File: tb/tb_ram16x4_ctrl.sv
// Directed self-checking bench for ram16x4_ctrl with a behavioural SN74189 model.
module tb_ram16x4_ctrl;

  localparam int unsigned WR = 2;
  localparam int unsigned RD = 2;
`ifdef RAM_CTRL_READBACK_EN
  localparam int unsigned RB = RD;
`else
  localparam int unsigned RB = 0;
`endif
  localparam int unsigned WLAT = WR + 3 + RB;
  localparam int unsigned RLAT = RD + 2;

  logic       CLK = 1'b0;
  logic       CLR;
  logic [3:0] A;
  logic [3:0] DI;
  wire  [3:0] DO;
  logic       S_bar;
  logic       W_bar;

  logic [3:0] mem [16];
  logic       stuck = 1'b0;
  int         w7_cnt = 0;
  int         total = 0;
  int         bad = 0;

  always #5 CLK = ~CLK;

  ram16x4_ctrl_if bus ();

  ram16x4_ctrl #(.WR_PULSE(WR), .RD_WAIT(RD)) dut (
    .CLK   (CLK),
    .CLR   (CLR),
    .host  (bus.slave),
    .A     (A),
    .DI    (DI),
    .DO    (DO),
    .S_bar (S_bar),
    .W_bar (W_bar)
  );

  // RAM model: writes while S_bar and W_bar are low, complemented output on read.
  always @(posedge CLK) begin
    if (S_bar === 1'b0 && W_bar === 1'b0) begin
      mem[A] <= DI;
      if (A == 4'h7) w7_cnt++;
    end
  end

  assign DO = (S_bar === 1'b0 && W_bar === 1'b1) ?
              {~mem[A][3:1], (~mem[A][0]) | stuck} : 4'bz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request at the current negedge; returns latency to done (0 = timeout).
  task automatic run_op(input logic w, input logic [3:0] ad, input logic [3:0] wd,
                        output int lat, output logic [3:0] rd, output logic ve);
    bus.req   = 1'b1;
    bus.we    = w;
    bus.addr  = ad;
    bus.wdata = wd;
    lat = 0;
    rd  = 'x;
    ve  = 1'bx;
    @(negedge CLK);
    bus.req = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (bus.done === 1'b1) begin
        lat = k;
        rd  = bus.rdata;
        ve  = bus.verify_err;
        break;
      end
      @(negedge CLK);
    end
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic [3:0] rd;
    logic       ve;
    int         dcnt;
    logic       s_low;
    logic       w_low;

    // Reset held two cycles with a pending request.
    CLR = 1'b1;
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 4'h7; bus.wdata = 4'hF;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst ready", 32'(bus.ready), 32'd1);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst S_bar", 32'(S_bar), 32'd1);
    check("rst W_bar", 32'(W_bar), 32'd1);
    check("rst A", 32'(A), 32'd0);
    check("rst DI", 32'(DI), 32'd0);
    check("rst rdata", 32'(bus.rdata), 32'd0);
    check("rst verify_err", 32'(bus.verify_err), 32'd0);
    check("rst no strobe", 32'(w7_cnt), 32'd0);
    CLR = 1'b0;
    bus.req = 1'b0;
    @(negedge CLK);
    check("post-rst idle ready", 32'(bus.ready), 32'd1);
    check("post-rst idle S_bar", 32'(S_bar), 32'd1);

    // Cycle-accurate write of 4'hA to address 3.
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 4'h3; bus.wdata = 4'hA;
    for (int k = 1; k <= int'(WLAT); k++) begin
      @(negedge CLK);
      if (k == 1) bus.req = 1'b0;
      w_low = (k >= 2) && (k <= int'(WR) + 1);
      s_low = w_low || ((RB != 0) && (k >= int'(WR) + 3) && (k <= int'(WR + RB) + 2));
      check($sformatf("wr3 S_bar k=%0d", k), 32'(S_bar), 32'(!s_low));
      check($sformatf("wr3 W_bar k=%0d", k), 32'(W_bar), 32'(!w_low));
      check($sformatf("wr3 done k=%0d", k), 32'(bus.done), 32'(k == int'(WLAT)));
      check($sformatf("wr3 A k=%0d", k), 32'(A), 32'h3);
      check($sformatf("wr3 DI k=%0d", k), 32'(DI), 32'hA);
    end
    @(negedge CLK);
    check("wr3 ready after done", 32'(bus.ready), 32'd1);
    check("wr3 ram word", 32'(mem[3]), 32'hA);

    // Fill all 16 words back-to-back, then read each back.
    for (int k = 0; k < 16; k++) begin
      run_op(1'b1, 4'(k), 4'((k + 5) % 16), lat, rd, ve);
      check($sformatf("fill lat a=%0d", k), 32'(lat), 32'(WLAT));
      check($sformatf("fill verify_err a=%0d", k), 32'(ve), 32'd0);
      check($sformatf("fill ready a=%0d", k), 32'(bus.ready), 32'd1);
    end
    for (int k = 0; k < 16; k++) begin
      check($sformatf("ram word a=%0d", k), 32'(mem[k]), 32'((k + 5) % 16));
    end
    for (int k = 0; k < 16; k++) begin
      run_op(1'b0, 4'(k), 4'h0, lat, rd, ve);
      check($sformatf("read lat a=%0d", k), 32'(lat), 32'(RLAT));
      check($sformatf("read data a=%0d", k), 32'(rd), 32'((k + 5) % 16));
    end

    // Requests to address 7 while busy must be dropped.
    w7_cnt = 0;
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 4'h2; bus.wdata = 4'h9;
    @(negedge CLK);
    bus.addr = 4'h7; bus.wdata = 4'h0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) bus.req = 1'b0;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge CLK);
    end
    check("busy write lat", 32'(lat), 32'(WLAT));
    @(negedge CLK);
    check("busy no strobe to 7", 32'(w7_cnt), 32'd0);
    check("busy ram word 7", 32'(mem[7]), 32'hC);
    run_op(1'b0, 4'h2, 4'h0, lat, rd, ve);
    check("after-done read lat", 32'(lat), 32'(RLAT));
    check("after-done read data", 32'(rd), 32'h9);
    run_op(1'b0, 4'h7, 4'h0, lat, rd, ve);
    check("addr7 unchanged", 32'(rd), 32'hC);

    // CLR in the first strobe cycle of a write.
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 4'h5; bus.wdata = 4'h0;
    @(negedge CLK);
    bus.req = 1'b0;
    @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    check("clr S_bar", 32'(S_bar), 32'd1);
    check("clr W_bar", 32'(W_bar), 32'd1);
    check("clr ready", 32'(bus.ready), 32'd1);
    check("clr done", 32'(bus.done), 32'd0);
    check("clr A", 32'(A), 32'd0);
    check("clr rdata", 32'(bus.rdata), 32'd0);
    dcnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (bus.done === 1'b1) dcnt++;
    end
    check("clr no done pulse", 32'(dcnt), 32'd0);
    run_op(1'b0, 4'h4, 4'h0, lat, rd, ve);
    check("post-clr read lat", 32'(lat), 32'(RLAT));
    check("post-clr read data", 32'(rd), 32'h9);

`ifdef RAM_CTRL_READBACK_EN
    // Read-back with DO bit 0 stuck high flags the write.
    stuck = 1'b1;
    run_op(1'b1, 4'h1, 4'h5, lat, rd, ve);
    check("rb stuck lat", 32'(lat), 32'(WLAT));
    check("rb stuck verify_err at done", 32'(ve), 32'd1);
    check("rb verify_err holds", 32'(bus.verify_err), 32'd1);
    check("rb rdata untouched", 32'(bus.rdata), 32'h9);
    stuck = 1'b0;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 4'h0; bus.wdata = 4'h0;
    @(negedge CLK);
    bus.req = 1'b0;
    check("rb cleared by request", 32'(bus.verify_err), 32'd0);
    repeat (RLAT) @(negedge CLK);
    @(negedge CLK);
    run_op(1'b1, 4'h1, 4'h6, lat, rd, ve);
    check("rb good write verify_err", 32'(ve), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
